// File: rtl/tl_pkg.sv
// Shared transaction-layer constants and the egress drain FSM encoding.
package tl_pkg;
  localparam int DATA_W    = 12;
  localparam int NUM_PORTS = 4;
  localparam int CNT_W     = 5;

  // cnt_idx code selecting the all-ports counter; codes above it read as zero
  localparam logic [2:0] TOTAL_IDX = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_POP,
    ST_CAPT,
    ST_SEND
  } state_t;
endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin pick: first requester at or above ptr, wrapping mod 4.
module rr_arbiter4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] grant,
  output logic       any_req
);
  logic [1:0] idx;

  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    grant   = ptr;
    idx     = '0;
    any_req = |req;
    // Walk from the farthest offset down so the nearest requester wins.
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) grant = idx;
    end
  end
endmodule

// File: rtl/egress_drain.sv
// Round-robin drain of four egress FIFOs onto a valid/ready stream, with drained-word counters.
// Optional build macro EGRESS_PARITY_EN adds an even-parity check and the parity_err output.
module egress_drain
  import tl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [3:0]        empty,
  input  logic [DATA_W-1:0] fifo_data0,
  input  logic [DATA_W-1:0] fifo_data1,
  input  logic [DATA_W-1:0] fifo_data2,
  input  logic [DATA_W-1:0] fifo_data3,
  output logic [3:0]        pop,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_port,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic [2:0]        cnt_idx,
  input  logic              cnt_req,
  output logic [CNT_W-1:0]  cnt_data,
  output logic              cnt_valid
`ifdef EGRESS_PARITY_EN
  ,
  output logic              parity_err
`endif
);
  if (NUM_PORTS != 4) begin : g_bad_ports
    $error("egress_drain is built for exactly 4 ports");
  end

  state_t            state, state_next;
  logic [1:0]        rr_ptr, grant, arb_grant;
  logic              arb_any, start;
  logic [DATA_W-1:0] sel_data;
  logic [CNT_W-1:0]  port_cnt [NUM_PORTS];
  logic [CNT_W-1:0]  total_cnt;

  rr_arbiter4 u_arb (
    .req     (~empty),
    .ptr     (rr_ptr),
    .grant   (arb_grant),
    .any_req (arb_any)
  );

  assign start = (state == ST_IDLE) && en && arb_any;

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (start) state_next = ST_POP;
      ST_POP:  state_next = ST_CAPT;
      ST_CAPT: state_next = ST_SEND;
      ST_SEND: if (out_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    sel_data = fifo_data0;
    unique case (grant)
      2'd0: sel_data = fifo_data0;
      2'd1: sel_data = fifo_data1;
      2'd2: sel_data = fifo_data2;
      2'd3: sel_data = fifo_data3;
      default: sel_data = fifo_data0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pop       <= '0;
      grant     <= '0;
      rr_ptr    <= '0;
      out_data  <= '0;
      out_port  <= '0;
      out_valid <= 1'b0;
      total_cnt <= '0;
      // NOTE: the counter array is reset explicitly because its values are architecturally visible.
      for (int i = 0; i < NUM_PORTS; i++) port_cnt[i] <= '0;
`ifdef EGRESS_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      pop <= '0;
      if (start) begin
        pop   <= 4'b0001 << arb_grant;
        grant <= arb_grant;
      end
      if (state == ST_CAPT) begin
        out_data        <= sel_data;
        out_port        <= grant;
        out_valid       <= 1'b1;
        port_cnt[grant] <= port_cnt[grant] + CNT_W'(1);
        total_cnt       <= total_cnt + CNT_W'(1);
        rr_ptr          <= grant + 2'd1;
`ifdef EGRESS_PARITY_EN
        // Even parity: any word whose bits XOR to one is flagged.
        parity_err      <= ^sel_data;
`endif
      end
      if (state == ST_SEND && out_ready) begin
        out_valid <= 1'b0;
`ifdef EGRESS_PARITY_EN
        parity_err <= 1'b0;
`endif
      end
    end
  end

  // Counter reads return the pre-increment value when a CAPT lands in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_valid <= 1'b0;
      cnt_data  <= '0;
    end else begin
      cnt_valid <= cnt_req;
      if (cnt_req) begin
        if (cnt_idx < TOTAL_IDX)       cnt_data <= port_cnt[cnt_idx[1:0]];
        else if (cnt_idx == TOTAL_IDX) cnt_data <= total_cnt;
        else                           cnt_data <= '0;
      end
    end
  end
endmodule

// File: tb/tb_egress_drain.sv
// Randomized self-checking bench for egress_drain: FIFO queues plus a round-robin order model.
module tb_egress_drain;
  import tl_pkg::*;

  typedef struct packed {
    logic [1:0]        port;
    logic [DATA_W-1:0] data;
  } word_t;

  logic              clk = 1'b0;
  logic              reset, en, out_ready, cnt_req;
  logic [3:0]        empty, pop;
  logic [DATA_W-1:0] fifo_data [4];
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_port;
  logic              out_valid, cnt_valid;
  logic [2:0]        cnt_idx;
  logic [CNT_W-1:0]  cnt_data;
`ifdef EGRESS_PARITY_EN
  logic              parity_err;
`endif

  int checks = 0;
  int failures = 0;

  logic [DATA_W-1:0] q [4][$];
  word_t             exp_q [$];
  int                model_cnt [5];
  int                model_ptr;

  egress_drain dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .empty      (empty),
    .fifo_data0 (fifo_data[0]),
    .fifo_data1 (fifo_data[1]),
    .fifo_data2 (fifo_data[2]),
    .fifo_data3 (fifo_data[3]),
    .pop        (pop),
    .out_data   (out_data),
    .out_port   (out_port),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .cnt_idx    (cnt_idx),
    .cnt_req    (cnt_req),
    .cnt_data   (cnt_data),
    .cnt_valid  (cnt_valid)
`ifdef EGRESS_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic void refresh_empty();
    for (int i = 0; i < 4; i++) empty[i] = (q[i].size() == 0);
  endfunction

  function automatic void clear_model();
    for (int i = 0; i < 4; i++) begin
      q[i].delete();
      fifo_data[i] = '0;
    end
    exp_q.delete();
    foreach (model_cnt[i]) model_cnt[i] = 0;
    model_ptr = 0;
    refresh_empty();
  endfunction

  // Expected delivery order: repeatedly take the first non-empty queue at or after the pointer.
  function automatic void plan_burst();
    int    k [4];
    int    left;
    int    p;
    word_t w;
    left = 0;
    for (int i = 0; i < 4; i++) begin
      k[i] = 0;
      left += q[i].size();
    end
    while (left > 0) begin
      p = 0;
      for (int off = 3; off >= 0; off--)
        if (k[(model_ptr + off) % 4] < q[(model_ptr + off) % 4].size()) p = (model_ptr + off) % 4;
      w.port = 2'(p);
      w.data = q[p][k[p]];
      exp_q.push_back(w);
      k[p]++;
      model_cnt[p]++;
      model_cnt[4]++;
      model_ptr = (p + 1) % 4;
      left--;
    end
  endfunction

  // Inputs are driven at the falling edge; this checks the coming rising edge's handshake,
  // then advances to the next falling edge and plays the FIFO side.
  task automatic tick();
    logic              hold;
    logic [DATA_W-1:0] hd;
    logic [1:0]        hp;
    word_t             e;
    hold = out_valid && !out_ready;
    hd   = out_data;
    hp   = out_port;
    if (out_valid && out_ready) begin
      check("pending_word", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("out_port", out_port, e.port);
        check("out_data", out_data, e.data);
      end
    end
    @(negedge clk);
    if (hold) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, hd);
      check("hold_port", out_port, hp);
    end
    check("pop_onehot", $countones(pop) <= 1, 1);
    for (int i = 0; i < 4; i++) begin
      if (pop[i]) begin
        check("pop_nonempty", q[i].size() > 0, 1);
        if (q[i].size() > 0) fifo_data[i] = q[i].pop_front();
      end
    end
    refresh_empty();
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    en        = 1'b0;
    out_ready = 1'b0;
    cnt_req   = 1'b0;
    cnt_idx   = '0;
    clear_model();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drain(input bit rand_mode, input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      en        = rand_mode ? ($urandom % 10 < 7) : 1'b1;
      out_ready = rand_mode ? ($urandom % 10 < 6) : 1'b1;
      tick();
      n++;
    end
    check("drain_left", exp_q.size(), 0);
    en        = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!out_valid && n < budget) begin
      tick();
      n++;
    end
    check("valid_seen", out_valid, 1);
  endtask

  task automatic read_cnt(input logic [2:0] idx, input int want);
    logic [CNT_W-1:0] w;
    w       = CNT_W'(want);
    cnt_idx = idx;
    cnt_req = 1'b1;
    tick();
    check($sformatf("cnt_valid_%0d", idx), cnt_valid, 1);
    check($sformatf("cnt_data_%0d", idx), cnt_data, w);
    cnt_req = 1'b0;
    tick();
    check("cnt_valid_drop", cnt_valid, 0);
    check("cnt_data_hold", cnt_data, w);
  endtask

  function automatic int model_read(input int idx);
    if (idx < 5) return model_cnt[idx] % (1 << CNT_W);
    return 0;
  endfunction

  initial begin
    do_reset();
    reset = 1'b1;
    tick();
    check("rst_pop", pop, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_port", out_port, 0);
    check("rst_cnt_valid", cnt_valid, 0);
    check("rst_cnt_data", cnt_data, 0);
`ifdef EGRESS_PARITY_EN
    check("rst_parity", parity_err, 0);
`endif
    reset = 1'b0;
    tick();

    // Single word from P1: pop one cycle, word on the output three cycles after IDLE.
    q[1].push_back(12'hA5C);
    refresh_empty();
    plan_burst();
    check("a_empty", empty, 4'b1101);
    en        = 1'b1;
    out_ready = 1'b1;
    tick();
    check("a_pop", pop, 4'b0010);
    tick();
    check("a_pop_clear", pop, 0);
    check("a_valid_early", out_valid, 0);
    tick();
    check("a_valid", out_valid, 1);
    check("a_data", out_data, 12'hA5C);
    check("a_port", out_port, 1);
    drain(1'b0, 20);

    // All four FIFOs non-empty for 8 words from a reset pointer.
    do_reset();
    for (int p = 0; p < 4; p++) repeat (2) q[p].push_back(DATA_W'($urandom));
    refresh_empty();
    plan_burst();
    drain(1'b0, 100);

    // Long back-pressure in SEND: no pop, stable word, then exactly one transfer.
    q[3].push_back(DATA_W'($urandom));
    refresh_empty();
    plan_burst();
    en        = 1'b1;
    out_ready = 1'b0;
    wait_valid(10);
    repeat (10) begin
      tick();
      check("stall_pop", pop, 0);
    end
    drain(1'b0, 20);
    read_cnt(3'd3, model_read(3));
    read_cnt(3'd4, model_read(4));

    // Randomized bursts with random en and out_ready, then every counter code.
    repeat (6) begin
      for (int p = 0; p < 4; p++)
        repeat ($urandom_range(0, 4)) q[p].push_back(DATA_W'($urandom));
      refresh_empty();
      plan_burst();
      drain(1'b1, 500);
      for (int i = 0; i < 8; i++) read_cnt(3'(i), model_read(i));
    end

    // 33 words from P2 wrap the 5-bit counters to 1.
    do_reset();
    repeat (33) q[2].push_back(DATA_W'($urandom));
    refresh_empty();
    plan_burst();
    drain(1'b0, 400);
    read_cnt(3'd2, 1);
    read_cnt(3'd4, 1);
    read_cnt(3'd6, 0);
    read_cnt(3'd0, 0);

`ifdef EGRESS_PARITY_EN
    do_reset();
    q[0].push_back(12'h001);
    refresh_empty();
    plan_burst();
    en        = 1'b1;
    out_ready = 1'b0;
    wait_valid(10);
    check("par_err_odd", parity_err, 1);
    en        = 1'b0;
    out_ready = 1'b1;
    tick();
    check("par_clear_valid", out_valid, 0);
    check("par_clear_err", parity_err, 0);
    q[0].push_back(12'h801);
    refresh_empty();
    plan_burst();
    en        = 1'b1;
    out_ready = 1'b0;
    wait_valid(10);
    check("par_err_even", parity_err, 0);
    drain(1'b0, 20);
`endif

    // Reset while a word is held in SEND.
    do_reset();
    q[0].push_back(DATA_W'($urandom));
    refresh_empty();
    plan_burst();
    en        = 1'b1;
    out_ready = 1'b0;
    wait_valid(10);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_pop", pop, 0);
    check("mid_rst_data", out_data, 0);
    @(negedge clk);
    clear_model();
    reset = 1'b0;
    en    = 1'b1;
    check("mid_rst_empty", empty, 4'hF);
    repeat (5) begin
      tick();
      check("post_rst_pop", pop, 0);
    end
    read_cnt(3'd0, 0);
    read_cnt(3'd4, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
